// File: rtl/ux607_regvec_access_pkg.sv
// Shared types and helpers for the register-vector access controller.
// The state encoding and the byte-mask expansion are used by the top and the merge unit.
package ux607_regvec_access_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] expand_mask(input logic [3:0] mask);
    logic [WORD_W-1:0] bits;
    for (int b = 0; b < 4; b++) begin
      bits[8*b +: 8] = {8{mask[b]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/ux607_regvec_bytemerge.sv
// Combinational byte-lane merge: lanes enabled in mask_i come from new_i,
// all other lanes keep old_i.
module ux607_regvec_bytemerge
  import ux607_regvec_access_pkg::*;
(
  input  logic [WORD_W-1:0] old_i,
  input  logic [WORD_W-1:0] new_i,
  input  logic [3:0]        mask_i,
  output logic [WORD_W-1:0] merged_o
);

  logic [WORD_W-1:0] bit_mask;

  assign bit_mask = expand_mask(mask_i);
  assign merged_o = (old_i & ~bit_mask) | (new_i & bit_mask);

endmodule

// File: rtl/ux607_regvec_access_ctrl.sv
// Single-outstanding bus responder for a bank of enable-loaded register vectors.
// Writes are read-modify-write against the live q, loaded in a one-cycle WRITE state.
module ux607_regvec_access_ctrl
  import ux607_regvec_access_pkg::*;
#(
  parameter int NREGS  = 4,
  parameter int ADDR_W = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic                    a_write,
  input  logic [ADDR_W-1:0]       a_addr,
  input  logic [WORD_W-1:0]       a_data,
  input  logic [3:0]              a_mask,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [WORD_W-1:0]       d_data,
  output logic                    d_error,
  output logic [NREGS*WORD_W-1:0] rv_d,
  output logic [NREGS-1:0]        rv_en,
  input  logic [NREGS*WORD_W-1:0] rv_q
);

  localparam int IDX_W = ADDR_W - 2;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [WORD_W-1:0] q_arr [NREGS];
  logic [IDX_W-1:0]  a_idx;
  logic              a_err;
  logic              accept;
  logic              wr_active;
  logic [WORD_W-1:0] rd_word, old_word, merged_word;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_unpack
      assign q_arr[gi] = rv_q[WORD_W*gi +: WORD_W];
    end
  endgenerate

  assign a_idx = a_addr[ADDR_W-1:2];
  assign a_err = (a_addr[1:0] != 2'b00) || ({1'b0, a_idx} >= (IDX_W+1)'(NREGS));

  // Reset gates the handshakes and the load enable in the same cycle it is raised.
  assign a_ready   = (state_q == IDLE)  && !reset;
  assign d_valid   = (state_q == RESP)  && !reset;
  assign wr_active = (state_q == WRITE) && !reset;
  assign accept    = a_valid && a_ready;
  assign d_data    = d_valid ? rdata_q : '0;
  assign d_error   = d_valid && err_q;

  always_comb begin
    rd_word  = '0;
    old_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (a_idx == IDX_W'(i)) rd_word = q_arr[i];
      if (idx_q == IDX_W'(i)) old_word = q_arr[i];
    end
  end

  ux607_regvec_bytemerge u_merge (
    .old_i   (old_word),
    .new_i   (wdata_q),
    .mask_i  (mask_q),
    .merged_o(merged_word)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = a_idx;
          wdata_d = a_data;
          mask_d  = a_mask;
          err_d   = a_err;
          rdata_d = (!a_write && !a_err) ? rd_word : '0;
          state_d = (a_write && !a_err && (a_mask != 4'b0000)) ? WRITE : RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    if (d_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_vec
      logic hit;
      assign hit       = wr_active && (idx_q == IDX_W'(gi));
      assign rv_en[gi] = hit;
      assign rv_d[WORD_W*gi +: WORD_W] = !wr_active ? '0 : (hit ? merged_word : q_arr[gi]);
    end
  endgenerate

endmodule

// File: tb/tb_ux607_regvec_access_ctrl.sv
// Bench for ux607_regvec_access_ctrl: emulates the register-vector bank and
// checks directed and random transactions against a word-array reference model.
module tb_ux607_regvec_access_ctrl;

  localparam int NREGS  = 4;
  localparam int ADDR_W = 6;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  a_valid = 1'b0;
  logic                  a_ready;
  logic                  a_write = 1'b0;
  logic [ADDR_W-1:0]     a_addr = '0;
  logic [31:0]           a_data = '0;
  logic [3:0]            a_mask = '0;
  logic                  d_valid;
  logic                  d_ready = 1'b0;
  logic [31:0]           d_data;
  logic                  d_error;
  logic [NREGS*32-1:0]   rv_d;
  logic [NREGS-1:0]      rv_en;
  logic [NREGS*32-1:0]   rv_q;

  int total = 0;
  int bad   = 0;

  // Emulated register-vector bank, with a side port for presetting contents.
  logic [31:0] vec [NREGS] = '{default: 32'h0};
  logic        pre_en  = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_val = '0;

  // Reference model of what each vector should hold.
  logic [31:0] model [NREGS] = '{default: 32'h0};

  always #5 clock = ~clock;

  ux607_regvec_access_ctrl #(.NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_write(a_write),
    .a_addr (a_addr),
    .a_data (a_data),
    .a_mask (a_mask),
    .d_valid(d_valid),
    .d_ready(d_ready),
    .d_data (d_data),
    .d_error(d_error),
    .rv_d   (rv_d),
    .rv_en  (rv_en),
    .rv_q   (rv_q)
  );

  always_comb begin
    rv_q = '0;
    for (int i = 0; i < NREGS; i++) rv_q[32*i +: 32] = vec[i];
  end

  always @(posedge clock) begin
    for (int i = 0; i < NREGS; i++) if (rv_en[i]) vec[i] <= rv_d[32*i +: 32];
    if (pre_en) vec[pre_idx] <= pre_val;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // The load enable must never have more than one bit set.
  always @(negedge clock) begin
    if (!reset) chk("rv_en_onehot", 64'($countones(rv_en) <= 1), 64'd1);
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic preset(input int idx, input logic [31:0] val);
    @(negedge clock);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    model[idx] = val;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  task automatic do_txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input int stall);
    int          idx;
    bit          err;
    bit          loads;
    int          n;
    logic [31:0] exp_d;
    logic [31:0] merged;
    idx   = int'(addr[ADDR_W-1:2]);
    err   = (addr[1:0] != 2'b00) || (idx >= NREGS);
    loads = wr && !err && (mask != 4'b0000);
    exp_d = 32'h0;
    if (!wr && !err) exp_d = model[idx];

    @(negedge clock);
    a_valid = 1'b1; a_write = wr; a_addr = addr; a_data = data; a_mask = mask;
    n = 0;
    while (!a_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("a_ready_wait", 64'(a_ready), 64'd1);
    @(negedge clock);
    a_valid = 1'b0; a_write = 1'($urandom); a_addr = ADDR_W'($urandom);
    a_data = $urandom; a_mask = 4'($urandom);

    if (loads) begin
      merged = merge_bytes(model[idx], data, mask);
      chk("wr_en", 64'(rv_en), 64'(1 << idx));
      chk("wr_rv_d", 64'(rv_d[32*idx +: 32]), 64'(merged));
      chk("wr_no_dvalid", 64'(d_valid), 64'd0);
      model[idx] = merged;
      @(negedge clock);
      chk("wr_loaded", 64'(vec[idx]), 64'(merged));
    end else begin
      chk("no_en", 64'(rv_en), 64'd0);
    end

    for (int k = 0; k <= stall; k++) begin
      d_ready = (k == stall);
      a_valid = (k == stall) ? 1'b0 : 1'($urandom_range(0, 1));
      chk("resp_dvalid", 64'(d_valid), 64'd1);
      chk("resp_ddata", 64'(d_data), 64'(exp_d));
      chk("resp_derror", 64'(d_error), 64'(err));
      chk("resp_aready", 64'(a_ready), 64'd0);
      chk("resp_en", 64'(rv_en), 64'd0);
      @(negedge clock);
    end
    a_valid = 1'b0;
    d_ready = 1'b0;
    chk("after_dvalid", 64'(d_valid), 64'd0);
    chk("after_aready", 64'(a_ready), 64'd1);
    $display("txn wr=%0d addr=%0h data=%0h mask=%0h stall=%0d err=%0d exp=%0h", wr, addr, data, mask,
             stall, err, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] ra;
    int n;

    // Reset values
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_aready", 64'(a_ready), 64'd0);
    chk("rst_dvalid", 64'(d_valid), 64'd0);
    chk("rst_ddata", 64'(d_data), 64'd0);
    chk("rst_derror", 64'(d_error), 64'd0);
    chk("rst_en", 64'(rv_en), 64'd0);
    chk("rst_rv_d", 64'(rv_d[63:0]), 64'd0);
    chk("rst_rv_d_hi", 64'(rv_d[127:64]), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_aready", 64'(a_ready), 64'd1);

    // Full write of idx1
    do_txn(1'b1, 6'h04, 32'hDEADBEEF, 4'hF, 0);
    do_txn(1'b0, 6'h04, 32'h0, 4'h0, 0);

    // Partial write then read-back
    preset(2, 32'h11223344);
    do_txn(1'b1, 6'h08, 32'hAABBCCDD, 4'b0101, 0);
    chk("partial_vec", 64'(vec[2]), 64'h11BB33DD);
    do_txn(1'b0, 6'h08, 32'h0, 4'h0, 0);

    // Misaligned read and out-of-range write
    do_txn(1'b0, 6'h05, 32'h0, 4'h0, 0);
    do_txn(1'b1, 6'h10, 32'h12345678, 4'hF, 1);

    // Backpressure on a read
    preset(3, 32'hCAFEF00D);
    do_txn(1'b0, 6'h0C, 32'h0, 4'h0, 5);

    // Zero-mask write leaves the vector alone
    preset(0, 32'h0BADF00D);
    do_txn(1'b1, 6'h00, 32'h12345678, 4'h0, 0);
    do_txn(1'b0, 6'h00, 32'h0, 4'h0, 0);

    // Reset raised during the WRITE cycle
    @(negedge clock);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 6'h08; a_data = 32'hFFFFFFFF; a_mask = 4'hF;
    n = 0;
    while (!a_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    a_valid = 1'b0;
    chk("mid_pre_en", 64'(rv_en), 64'h4);
    reset = 1'b1;
    #1;
    chk("mid_rst_en", 64'(rv_en), 64'd0);
    chk("mid_rst_dvalid", 64'(d_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_vec", 64'(vec[2]), 64'(model[2]));
    @(negedge clock);
    chk("mid_rst_aready", 64'(a_ready), 64'd1);
    chk("mid_rst_dvalid2", 64'(d_valid), 64'd0);
    do_txn(1'b0, 6'h08, 32'h0, 4'h0, 0);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) ra = ADDR_W'($urandom);
      else ra = {4'($urandom_range(0, NREGS - 1)), 2'b00};
      do_txn(1'($urandom), ra, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ux607_regvec_access_ctrl.md
Name: ux607_regvec_access_ctrl

Overview:
- Bus-side responder that writes and reads a bank of NREGS 32-bit enable-loaded register vectors (ux607_AsyncResetRegVec-style).
- Drives each vector's d/en pair and reads back its q.
- Accepts single-beat read/write requests on a valid/ready channel and returns one response per request.
- Performs byte-masked writes as read-modify-write against the current q.
- Sits between the peripheral bus fragment and the peripheral's register-vector bank.

Parameters:
- NREGS, 4: number of 32-bit register vectors served; range 1..16.
- ADDR_W, 6: byte-address width of a_addr; must satisfy 2^(ADDR_W-2) >= NREGS.

Ports:
- clock  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- a_valid  input  1  request valid.
- a_ready  output  1  request accepted when a_valid && a_ready.
- a_write  input  1  1 = write, 0 = read.
- a_addr  input  ADDR_W  byte address; word index = a_addr[ADDR_W-1:2].
- a_data  input  32  write data.
- a_mask  input  4  byte enables for write.
- d_valid  output  1  response valid.
- d_ready  input  1  response consumed when d_valid && d_ready.
- d_data  output  32  read data; 0 for writes and errors.
- d_error  output  1  1 = misaligned or out-of-range address.
- rv_d  output  NREGS*32  per-vector next data; slice i = [32*i+31:32*i].
- rv_en  output  NREGS  per-vector load enable.
- rv_q  input  NREGS*32  per-vector current value.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high; the port names are clock and reset.
- Reset values: state=IDLE, a_ready=0 during reset then 1 in IDLE, d_valid=0, d_data=0, d_error=0, rv_en=0, rv_d=0.
- States: IDLE, WRITE, RESP.
- IDLE:
  - a_ready=1; all other outputs idle.
  - On acceptance, latch write, idx, data, mask.
  - Error when a_addr[1:0]!=0 or idx>=NREGS.
  - Error or read → RESP. On a read, d_data is captured from rv_q slice idx in the accept cycle.
  - Valid write with a_mask!=0 → WRITE.
  - Valid write with a_mask==0 → RESP with no load.
- WRITE (exactly 1 cycle):
  - rv_en[idx]=1 and all other rv_en bits 0.
  - rv_d slice idx = (rv_q[idx] & ~M) | (data & M), where M is the byte mask expanded to bits.
  - Other rv_d slices = their rv_q (harmless, since en=0).
  - Next state RESP.
- RESP:
  - d_valid=1 with d_data/d_error held stable until d_ready.
  - On d_valid && d_ready → IDLE. a_ready=0 throughout.
- Latency, with accept at cycle T:
  - Read or error: d_valid from T+1.
  - Write: rv_en pulse at T+1; the vector updates at the T+1→T+2 edge; d_valid from T+2.
  - Back-to-back: the next accept is no earlier than the cycle after the response handshake; one outstanding transaction maximum.
- Write-then-read to the same idx returns the merged value, since the load completes before the write response.
- Errors: no rv_en pulse ever; d_error=1, d_data=0.
- rv_en is one-hot or zero at all times and never asserted outside WRITE.
- Reset mid-operation: any state → IDLE next cycle; a pending rv_en is dropped (no load at that edge); the response is discarded.
- d_ready held high continuously: the response lasts exactly one cycle.
- Stalled d_ready: outputs stay stable indefinitely.
- a_valid outside IDLE is ignored; a_* may change freely while a_ready=0.

Decomposition:
- Package ux607_regvec_access_pkg holds:
  - state enum (IDLE/WRITE/RESP), 2-bit;
  - constant WORD_W=32;
  - function expanding a 4-bit byte mask to 32 bits.
- Sub-module ux607_regvec_bytemerge: combinational (old, new, mask) → merged 32-bit word. Instantiated once on the selected slice.

Test Plan:
- Reset then write: reset, then write idx1 (a_addr=0x04), data 0xDEADBEEF, mask 0xF, with rv_q1=0.
  - Required: rv_en=0b0010 for exactly one cycle at T+1 with rv_d1=0xDEADBEEF.
  - Required: d_valid at T+2 with d_error=0.
- Partial write: rv_q2=0x11223344, write a_addr=0x08, data 0xAABBCCDD, mask 0b0101.
  - Required: rv_d2=0x11BB33DD at the rv_en pulse.
  - Required: a following read of 0x08 returns 0x11BB33DD at T+1.
- Error cases: read a_addr=0x05 (misaligned), then write a_addr=0x10 with NREGS=4.
  - Required: both responses have d_error=1 and d_data=0.
  - Required: rv_en stays 0 throughout.
- Backpressure: read idx3 with rv_q3=0xCAFEF00D and d_ready held low 5 cycles.
  - Required: d_valid and d_data=0xCAFEF00D stable for all 5 cycles.
  - Required: a_ready=0 during the stall; a_valid pulses are ignored.
  - Required: after d_ready=1, IDLE and a_ready=1 on the next cycle.
- Zero-mask write: write idx0 with mask 0x0.
  - Required: no rv_en pulse; d_valid at T+1 with d_error=0.
- Reset mid-operation: assert reset in the WRITE cycle.
  - Required: rv_en=0 in that cycle; rv_q unchanged.
  - Required: d_valid=0; state IDLE after reset deasserts.
